// File: rtl/onehot_req_encoder.sv
// Gathers request pulses into a pending vector and issues their indices one per valid/ready transfer.
// Define ONEHOT_ENC_RR_EN for round-robin selection; the default build uses fixed lowest-index priority.
module onehot_req_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    output logic             all_pending,
    output logic             drop
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             drop_q, drop_d;

    logic [N-1:0]     set_mask_s;
    logic [N-1:0]     clr_mask_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             load_s;
    int               search_start_s;

`ifdef ONEHOT_ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    // First set bit of vec when scanning upward from start and wrapping past N-1.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [N-1:0] vec, input int start);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] pos;
        int               j;
        res = {IDX_W{1'b0}};
        // Walk the order backwards so the earliest hit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            j   = start + i;
            j   = (j >= N) ? (j - N) : j;
            pos = IDX_W'(j);
            res = vec[pos] ? pos : res;
        end
        return res;
    endfunction

    // Summary flags straight from the pending register.
    always_comb begin
        any_pending = |pending_q;
        all_pending = &pending_q;
    end

    // Where the priority search begins.
    always_comb begin
`ifdef ONEHOT_ENC_RR_EN
        search_start_s = (int'(ptr_q) + 1) % N;
`else
        search_start_s = 0;
`endif
        sel_idx_s = pick_idx(pending_q, search_start_s);
    end

    // Output FSM: decides when a new index is loaded and which pending bit it clears.
    always_comb begin
        state_d     = state_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        load_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    load_s      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready && any_pending) begin
                    load_s      = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        if (load_s) begin
            out_idx_d  = sel_idx_s;
            clr_mask_s = {{(N-1){1'b0}}, 1'b1} << sel_idx_s;
        end else begin
            clr_mask_s = {N{1'b0}};
        end
    end

    // Pending bookkeeping: a fresh set overrides the clear of the bit just issued.
    always_comb begin
        set_mask_s = en ? req : {N{1'b0}};
        pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
        drop_d     = |(set_mask_s & pending_q & ~clr_mask_s);
    end

`ifdef ONEHOT_ENC_RR_EN
    // Round-robin pointer follows the last issued index.
    always_comb begin
        if (load_s) begin
            ptr_d = sel_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; N-1 at reset so the first grant matches fixed priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= {N{1'b0}};
            out_idx_q   <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Directed and randomized checks of onehot_req_encoder against a behavioural pending/issue model.
module tb_onehot_req_encoder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] out_idx;
    logic       out_valid;
    logic [3:0] pending;
    logic       any_pending;
    logic       all_pending;
    logic       drop;

    int checks = 0;
    int errors = 0;

    // Model state: the set of waiting indices plus what the output port is presenting.
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_idx;
    logic       m_drop;
    int         m_ptr;

    onehot_req_encoder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .pending(pending), .any_pending(any_pending), .all_pending(all_pending),
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 4'b0000;
        m_valid = 1'b0;
        m_idx   = 2'd0;
        m_drop  = 1'b0;
        m_ptr   = N - 1;
    endtask

    // Which waiting index the encoder should hand out next.
    function automatic int model_pick(input logic [3:0] p, input int ptr);
        int start;
`ifdef ONEHOT_ENC_RR_EN
        start = (ptr + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".pending"}, 32'(pending), 32'(m_pend));
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".idx"}, 32'(out_idx), 32'(m_idx));
        chk({tag, ".any"}, 32'(any_pending), 32'(m_pend != 4'b0000));
        chk({tag, ".all"}, 32'(all_pending), 32'($countones(m_pend) == N));
        chk({tag, ".drop"}, 32'(drop), 32'(m_drop));
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input logic e, input logic [3:0] r, input logic rdy, input string tag);
        logic [3:0] set_bits, cleared, n_pend;
        logic       n_valid;
        logic [1:0] n_idx;
        int         k, n_ptr;
        en = e; req = r; out_ready = rdy;
        set_bits = e ? r : 4'b0000;
        cleared  = 4'b0000;
        n_valid  = m_valid;
        n_idx    = m_idx;
        n_ptr    = m_ptr;
        if (!m_valid || rdy) begin
            k = model_pick(m_pend, m_ptr);
            if (k >= 0) begin
                n_valid    = 1'b1;
                n_idx      = 2'(k);
                n_ptr      = k;
                cleared[k] = 1'b1;
            end else begin
                n_valid = 1'b0;
            end
        end
        n_pend = (m_pend & ~cleared) | set_bits;
        m_drop = |(set_bits & m_pend & ~cleared);
        @(posedge clk);
        #1;
        m_pend = n_pend; m_valid = n_valid; m_idx = n_idx; m_ptr = n_ptr;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; req = 4'b0000; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] rr_exp [3];
        rst_n = 1'b0; en = 1'b0; req = 4'b0000; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // Single request: two-cycle latency.
        do_reset();
        step(1'b1, 4'b0100, 1'b1, "lat.e1");
        chk("lat.pend_after_k", 32'(pending), 32'h4);
        step(1'b1, 4'b0000, 1'b1, "lat.e2");
        chk("lat.valid", 32'(out_valid), 32'h1);
        chk("lat.idx", 32'(out_idx), 32'h2);
        chk("lat.any", 32'(any_pending), 32'h0);
        step(1'b1, 4'b0000, 1'b1, "lat.e3");

        // All four at once, drained back to back.
        do_reset();
        step(1'b1, 4'b1111, 1'b1, "all.cap");
        chk("all.all_pending", 32'(all_pending), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0000, 1'b1, "all.drain");
            chk("all.seq_idx", 32'(out_idx), 32'(i));
            chk("all.all_low", 32'(all_pending), 32'h0);
        end
        step(1'b1, 4'b0000, 1'b1, "all.end");
        chk("all.valid_drop", 32'(out_valid), 32'h0);

        // Back-pressure holds the presented index.
        do_reset();
        step(1'b1, 4'b0011, 1'b0, "bp.cap");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000, 1'b0, "bp.hold");
            chk("bp.idx", 32'(out_idx), 32'h0);
            chk("bp.pend", 32'(pending), 32'h2);
        end
        step(1'b1, 4'b0000, 1'b1, "bp.release");
        chk("bp.next_idx", 32'(out_idx), 32'h1);
        step(1'b1, 4'b0000, 1'b1, "bp.idle");

        // Drop on a waiting bit; set beats clear on the bit being issued.
        do_reset();
        step(1'b1, 4'b0011, 1'b0, "drop.cap");
        step(1'b1, 4'b0000, 1'b0, "drop.hold");
        step(1'b1, 4'b0010, 1'b0, "drop.hit");
        chk("drop.pulse", 32'(drop), 32'h1);
        chk("drop.pend", 32'(pending), 32'h2);
        step(1'b1, 4'b0000, 1'b0, "drop.after");
        chk("drop.one_cycle", 32'(drop), 32'h0);
        step(1'b1, 4'b0010, 1'b1, "drop.setclr");
        chk("drop.setclr_pend", 32'(pending), 32'h2);
        chk("drop.setclr_nodrop", 32'(drop), 32'h0);
        chk("drop.setclr_idx", 32'(out_idx), 32'h1);
        step(1'b1, 4'b0000, 1'b1, "drop.re1");
        step(1'b1, 4'b0000, 1'b1, "drop.re2");

        // Capture disabled while the backlog drains.
        do_reset();
        step(1'b1, 4'b0110, 1'b0, "en.cap");
        step(1'b1, 4'b0000, 1'b0, "en.hold");
        step(1'b0, 4'b1111, 1'b0, "en.blocked");
        chk("en.pend", 32'(pending), 32'h4);
        chk("en.nodrop", 32'(drop), 32'h0);
        step(1'b0, 4'b1111, 1'b1, "en.drain");
        chk("en.drain_idx", 32'(out_idx), 32'h2);
        step(1'b0, 4'b1111, 1'b1, "en.empty");
        chk("en.empty_valid", 32'(out_valid), 32'h0);

        // Continuous low-index traffic with one late high request.
`ifdef ONEHOT_ENC_RR_EN
        rr_exp = '{2'd0, 2'd3, 2'd0};
`else
        rr_exp = '{2'd0, 2'd0, 2'd0};
`endif
        do_reset();
        step(1'b1, 4'b1001, 1'b1, "rr.cap");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0001, 1'b1, "rr.stream");
            chk("rr.grant", 32'(out_idx), 32'(rr_exp[i]));
        end
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b1, "rr.drain");

        // Asynchronous reset in HOLD with a drop pulse showing.
        do_reset();
        step(1'b1, 4'b0011, 1'b0, "ar.cap");
        step(1'b1, 4'b0000, 1'b0, "ar.hold");
        step(1'b1, 4'b0010, 1'b0, "ar.drop");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(out_valid), 32'h0);
        chk("ar.pend", 32'(pending), 32'h0);
        chk("ar.drop", 32'(drop), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
